// File: rtl/comparator_nb_seq.sv
// Sequential magnitude comparator: walks the latched operands CHUNK bits per cycle
// from the MSB chunk down, optionally stopping at the first chunk that differs.
module comparator_nb_seq #(
    parameter int WIDTH      = 8,
    parameter int CHUNK      = 2,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             A_great_B,
    output logic             A_equal_B,
    output logic             A_less_B,
    output logic             dbg_state
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [CHUNK-1:0] MSB_MASK = CHUNK'(1) << (CHUNK - 1);

    // Handshake: start is taken on any rising edge where the FSM is IDLE; busy is
    // high from that edge until the edge that raises the one-cycle done pulse.
    typedef enum logic {
        IDLE    = 1'b0,
        COMPARE = 1'b1
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_q, b_q;
    logic             signed_q;
    logic [IDX_W-1:0] idx;
    logic             diff_found;
    logic             found_gt;

    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic             chunk_differs, chunk_gt, last_chunk;
    logic             accept, finish;

    // Offset-binary trick: flipping the sign bit of both operands makes an
    // unsigned compare of the top chunk order two's-complement values correctly.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == IDX_W'(i)) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
        if (signed_q && idx == LAST_IDX) begin
            a_chunk = a_chunk ^ MSB_MASK;
            b_chunk = b_chunk ^ MSB_MASK;
        end
        chunk_differs = (a_chunk != b_chunk);
        chunk_gt      = (a_chunk > b_chunk);
        last_chunk    = (idx == '0);
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = COMPARE;
                end
            end
            COMPARE: begin
                if (last_chunk || (EARLY_EXIT != 0 && chunk_differs)) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            signed_q   <= 1'b0;
            idx        <= '0;
            diff_found <= 1'b0;
            found_gt   <= 1'b0;
            done       <= 1'b0;
            A_great_B  <= 1'b0;
            A_equal_B  <= 1'b0;
            A_less_B   <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                a_q        <= A;
                b_q        <= B;
                signed_q   <= signed_mode;
                idx        <= LAST_IDX;
                diff_found <= 1'b0;
                found_gt   <= 1'b0;
            end else if (state == COMPARE) begin
                if (!finish) idx <= idx - 1'b1;
                // Only the first differing chunk decides; later chunks are ignored.
                if (chunk_differs && !diff_found) begin
                    diff_found <= 1'b1;
                    found_gt   <= chunk_gt;
                end
                if (finish) begin
                    if (diff_found) begin
                        A_great_B <= found_gt;
                        A_equal_B <= 1'b0;
                        A_less_B  <= !found_gt;
                    end else if (chunk_differs) begin
                        A_great_B <= chunk_gt;
                        A_equal_B <= 1'b0;
                        A_less_B  <= !chunk_gt;
                    end else begin
                        A_great_B <= 1'b0;
                        A_equal_B <= 1'b1;
                        A_less_B  <= 1'b0;
                    end
                end
            end
        end
    end

    assign busy      = (state == COMPARE);
    assign dbg_state = state;

endmodule

// File: tb/tb_comparator_nb_seq.sv
// Bench for comparator_nb_seq: three instances (early exit, full scan, 2-bit) driven
// by directed and random operations, checked against an arithmetic reference model.
module tb_comparator_nb_seq;

    logic clk;
    logic rst;

    logic       start0, sm0, busy0, done0, gt0, eq0, lt0, st0;
    logic [7:0] a0, b0;
    logic       start1, sm1, busy1, done1, gt1, eq1, lt1, st1;
    logic [7:0] a1, b1;
    logic       start2, sm2, busy2, done2, gt2, eq2, lt2, st2;
    logic [1:0] a2, b2;

    int total;
    int passed;

    comparator_nb_seq #(.WIDTH(8), .CHUNK(2), .EARLY_EXIT(1)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .signed_mode(sm0), .A(a0), .B(b0),
        .busy(busy0), .done(done0), .A_great_B(gt0), .A_equal_B(eq0), .A_less_B(lt0),
        .dbg_state(st0)
    );

    comparator_nb_seq #(.WIDTH(8), .CHUNK(2), .EARLY_EXIT(0)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .signed_mode(sm1), .A(a1), .B(b1),
        .busy(busy1), .done(done1), .A_great_B(gt1), .A_equal_B(eq1), .A_less_B(lt1),
        .dbg_state(st1)
    );

    comparator_nb_seq #(.WIDTH(2), .CHUNK(1), .EARLY_EXIT(1)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .signed_mode(sm2), .A(a2), .B(b2),
        .busy(busy2), .done(done2), .A_great_B(gt2), .A_equal_B(eq2), .A_less_B(lt2),
        .dbg_state(st2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic set_inputs(input int d, input logic s, input logic sm,
                              input logic [7:0] a, input logic [7:0] b);
        case (d)
            0: begin start0 = s; sm0 = sm; a0 = a; b0 = b; end
            1: begin start1 = s; sm1 = sm; a1 = a; b1 = b; end
            default: begin start2 = s; sm2 = sm; a2 = a[1:0]; b2 = b[1:0]; end
        endcase
    endtask

    function automatic logic get_done(input int d);
        case (d)
            0: return done0;
            1: return done1;
            default: return done2;
        endcase
    endfunction

    function automatic logic [2:0] get_flags(input int d);
        case (d)
            0: return {gt0, eq0, lt0};
            1: return {gt1, eq1, lt1};
            default: return {gt2, eq2, lt2};
        endcase
    endfunction

    // One operation: start for one edge, then present (ma, mb, msm) while busy.
    // lat = edges after the start edge until done is seen; -1 on timeout.
    task automatic drive_op(input int d, input logic [7:0] a, input logic [7:0] b,
                            input logic sm, input logic [7:0] ma, input logic [7:0] mb,
                            input logic msm, output int lat, output logic [2:0] flags);
        lat   = -1;
        flags = 3'b000;
        @(negedge clk);
        set_inputs(d, 1'b1, sm, a, b);
        @(posedge clk);
        @(negedge clk);
        set_inputs(d, 1'b0, msm, ma, mb);
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (get_done(d)) begin
                lat   = e;
                flags = get_flags(d);
                break;
            end
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model(input int w, input int c, input int ee, input logic [7:0] a,
                         input logic [7:0] b, input logic sm, output int lat,
                         output logic [2:0] flags);
        int va, vb, diff, n, first, mask;
        va = int'(a) & ((1 << w) - 1);
        vb = int'(b) & ((1 << w) - 1);
        if (sm) begin
            if (va >= (1 << (w - 1))) va = va - (1 << w);
            if (vb >= (1 << (w - 1))) vb = vb - (1 << w);
        end
        flags = (va > vb) ? 3'b100 : (va == vb) ? 3'b010 : 3'b001;
        diff  = (int'(a) ^ int'(b)) & ((1 << w) - 1);
        n     = w / c;
        mask  = (1 << c) - 1;
        first = 0;
        for (int k = 1; k <= n; k++)
            if (first == 0 && ((diff >> (w - k * c)) & mask) != 0) first = k;
        lat = (ee != 0 && first != 0) ? first : n;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int seen;
        rst = 1'b1;
        set_inputs(0, 1'b1, 1'b0, 8'h00, 8'h00);
        set_inputs(1, 1'b1, 1'b0, 8'h00, 8'h00);
        set_inputs(2, 1'b1, 1'b0, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({busy0, done0, gt0, eq0, lt0} !== 5'b0)
            $display("FAIL reset_dut0: got %b expected 00000", {busy0, done0, gt0, eq0, lt0});
        else passed++;
        total++;
        if ({busy1, done1, gt1, eq1, lt1} !== 5'b0)
            $display("FAIL reset_dut1: got %b expected 00000", {busy1, done1, gt1, eq1, lt1});
        else passed++;
        total++;
        if ({busy2, done2, gt2, eq2, lt2} !== 5'b0)
            $display("FAIL reset_dut2: got %b expected 00000", {busy2, done2, gt2, eq2, lt2});
        else passed++;
        set_inputs(1, 1'b0, 1'b0, 8'h00, 8'h00);
        set_inputs(2, 1'b0, 1'b0, 8'h00, 8'h00);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        total++;
        if (busy0 !== 1'b1) $display("FAIL first_accept_busy: got %b expected 1", busy0);
        else passed++;
        seen = 0;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (done0) begin seen = e; break; end
        end
        total++;
        if (seen != 4 || {gt0, eq0, lt0} !== 3'b010)
            $display("FAIL first_op: got lat %0d flags %b expected lat 4 flags 010", seen, {gt0, eq0, lt0});
        else passed++;
    endtask

    task automatic test_spec_vectors();
        int lat;
        logic [2:0] f;
        drive_op(0, 8'hA5, 8'hA5, 1'b0, 8'hA5, 8'hA5, 1'b0, lat, f);
        total++;
        if (lat != 4 || f !== 3'b010)
            $display("FAIL a5_a5: got lat %0d flags %b expected lat 4 flags 010", lat, f);
        else passed++;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (done0 !== 1'b0 || {gt0, eq0, lt0} !== 3'b010)
            $display("FAIL done_one_cycle: got done %b flags %b expected done 0 flags 010", done0, {gt0, eq0, lt0});
        else passed++;
        drive_op(0, 8'h80, 8'h7F, 1'b0, 8'h80, 8'h7F, 1'b0, lat, f);
        total++;
        if (lat != 1 || f !== 3'b100)
            $display("FAIL 80_7f_unsigned: got lat %0d flags %b expected lat 1 flags 100", lat, f);
        else passed++;
        drive_op(0, 8'h80, 8'h7F, 1'b1, 8'h80, 8'h7F, 1'b1, lat, f);
        total++;
        if (lat != 1 || f !== 3'b001)
            $display("FAIL 80_7f_signed: got lat %0d flags %b expected lat 1 flags 001", lat, f);
        else passed++;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        set_inputs(0, 1'b1, 1'b0, 8'h12, 8'h13);
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        set_inputs(0, 1'b1, 1'b0, 8'hFF, 8'h00);
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        total++;
        if (busy0 !== 1'b1 || done0 !== 1'b0)
            $display("FAIL ignore_start_busy: got busy %b done %b expected busy 1 done 0", busy0, done0);
        else passed++;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (done0 !== 1'b0) $display("FAIL no_early_done: got %b expected 0", done0);
        else passed++;
        set_inputs(0, 1'b1, 1'b0, 8'hF0, 8'h0F);
        @(posedge clk);
        @(negedge clk);
        total++;
        if (done0 !== 1'b1 || {gt0, eq0, lt0} !== 3'b001)
            $display("FAIL 12_13_result: got done %b flags %b expected done 1 flags 001", done0, {gt0, eq0, lt0});
        else passed++;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        total++;
        if (busy0 !== 1'b1 || done0 !== 1'b0)
            $display("FAIL back_to_back_accept: got busy %b done %b expected busy 1 done 0", busy0, done0);
        else passed++;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (done0 !== 1'b1 || {gt0, eq0, lt0} !== 3'b100)
            $display("FAIL back_to_back_result: got done %b flags %b expected done 1 flags 100", done0, {gt0, eq0, lt0});
        else passed++;
    endtask

    task automatic test_reset_mid_op();
        int seen;
        @(negedge clk);
        set_inputs(0, 1'b1, 1'b0, 8'h00, 8'h01);
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({busy0, done0, gt0, eq0, lt0} !== 5'b0)
            $display("FAIL async_reset_mid_op: got %b expected 00000", {busy0, done0, gt0, eq0, lt0});
        else passed++;
        @(posedge clk);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (done0 || busy0) seen++;
        end
        total++;
        if (seen != 0) $display("FAIL no_done_after_reset: got %0d active cycles expected 0", seen);
        else passed++;
    endtask

    task automatic test_no_early_exit();
        int lat;
        logic [2:0] f;
        drive_op(1, 8'hC0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, lat, f);
        total++;
        if (lat != 4 || f !== 3'b100)
            $display("FAIL full_scan_c0_00: got lat %0d flags %b expected lat 4 flags 100", lat, f);
        else passed++;
        drive_op(1, 8'h80, 8'h7F, 1'b1, 8'h7F, 8'h80, 1'b0, lat, f);
        total++;
        if (lat != 4 || f !== 3'b001)
            $display("FAIL full_scan_signed: got lat %0d flags %b expected lat 4 flags 001", lat, f);
        else passed++;
    endtask

    task automatic test_two_bit();
        int lat, elat;
        logic [2:0] f, ef;
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                model(2, 1, 1, 8'(a), 8'(b), 1'b0, elat, ef);
                drive_op(2, 8'(a), 8'(b), 1'b0, 8'(3 - a), 8'(b ^ 1), 1'b0, lat, f);
                total++;
                if (lat != elat || f !== ef)
                    $display("FAIL two_bit a=%0d b=%0d: got lat %0d flags %b expected lat %0d flags %b",
                             a, b, lat, f, elat, ef);
                else passed++;
            end
        end
    endtask

    task automatic test_random();
        int lat, elat, d;
        logic [2:0] f, ef;
        logic [7:0] a, b;
        logic sm;
        for (int i = 0; i < 40; i++) begin
            d  = i % 2;
            a  = 8'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? a : 8'($urandom);
            if ($urandom_range(0, 2) == 0) b[7:4] = a[7:4];
            sm = 1'($urandom_range(0, 1));
            model(8, 2, (d == 0) ? 1 : 0, a, b, sm, elat, ef);
            drive_op(d, a, b, sm, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), lat, f);
            total++;
            if (lat != elat || f !== ef)
                $display("FAIL random dut%0d a=%h b=%h s=%b: got lat %0d flags %b expected lat %0d flags %b",
                         d, a, b, sm, lat, f, elat, ef);
            else passed++;
        end
    endtask

    initial begin
        total  = 0;
        passed = 0;
        rst    = 1'b1;
        set_inputs(0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_inputs(1, 1'b0, 1'b0, 8'h00, 8'h00);
        set_inputs(2, 1'b0, 1'b0, 8'h00, 8'h00);
        test_reset();
        test_spec_vectors();
        test_back_to_back();
        test_reset_mid_op();
        test_no_early_exit();
        test_two_bit();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/comparator_nb_seq.md
COMPARATOR_NB_SEQ -- requirements
Module: comparator_nb_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; SHALL be >= 2.
REQ-002 Parameter CHUNK, default 2, bits compared per cycle; WIDTH SHALL be an integer multiple of CHUNK; N = WIDTH/CHUNK.
REQ-003 Parameter EARLY_EXIT, default 1, 1 = finish on first differing chunk, 0 = always scan all N chunks.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  request; sampled only while idle.
REQ-007 signed_mode  input  1  1 = A, B two's-complement; 0 = unsigned.
REQ-008 A  input  WIDTH  operand A.
REQ-009 B  input  WIDTH  operand B.
REQ-010 busy  output  1  high while a comparison is in progress.
REQ-011 done  output  1  one-cycle pulse, result flags updated.
REQ-012 A_great_B  output  1  registered result A > B.
REQ-013 A_equal_B  output  1  registered result A == B.
REQ-014 A_less_B  output  1  registered result A < B.

Function
REQ-015 FSM SHALL have two states: IDLE, COMPARE.
REQ-016 IDLE, start=1 at an edge: latch A, B, signed_mode; chunk index = N-1 (MSB chunk); go COMPARE; busy=1 from that edge.
REQ-017 IDLE, start=0: remain IDLE; outputs other than done hold.
REQ-018 COMPARE: each edge compares one latched chunk pair, MSB chunk first, index decrementing by 1.
REQ-019 signed_mode=1: MSB of each operand SHALL be inverted before comparison (offset-binary); applies to the MSB chunk only.
REQ-020 First chunk pair that differs fixes the result (greater/less by that chunk); later chunks SHALL NOT change it.
REQ-021 EARLY_EXIT=1: at the edge processing the first differing chunk, go IDLE, busy=0, done=1, flags updated.
REQ-022 EARLY_EXIT=0, or no chunk differs: at the edge processing chunk 0, go IDLE, busy=0, done=1, flags updated; all equal -> A_equal_B.
REQ-023 Latency: done high after exactly m edges following the start edge; m = 1-based position (from MSB) of the first differing chunk if EARLY_EXIT=1 and a difference exists, else m = N.
REQ-024 After the first completion, exactly one result flag SHALL be high; flags hold until the next done.
REQ-025 done SHALL be high for exactly one cycle per accepted start.
REQ-026 start while busy=1 SHALL be ignored (no queueing, no restart).
REQ-027 start high in the done cycle SHALL be accepted (FSM is IDLE), giving back-to-back operation with no idle gap.
REQ-028 A, B, signed_mode changes while busy SHALL NOT affect the result in progress.
REQ-029 WIDTH=2, CHUNK=1 SHALL give flags identical to the existing 2-bit comparator for all 16 unsigned input pairs.

Reset
REQ-030 rst=1 SHALL immediately, without a clock: state=IDLE, busy=0, done=0, A_great_B=0, A_equal_B=0, A_less_B=0, latched operands and index cleared.
REQ-031 rst asserted mid-COMPARE SHALL abandon the operation; no done pulse for it after rst deasserts.
REQ-032 start SHALL be ignored while rst=1; first acceptance at the first edge with rst=0.

Verification (WIDTH=8, CHUNK=2, EARLY_EXIT=1 unless stated)
REQ-033 Unsigned A=0xA5, B=0xA5 -> done 4 edges after start; A_equal_B=1, others 0.
REQ-034 A=0x80, B=0x7F: unsigned -> done after 1 edge, A_great_B=1; signed -> done after 1 edge, A_less_B=1.
REQ-035 Unsigned A=0x12, B=0x13 -> done after 4 edges, A_less_B=1; start pulsed at edge 2 of this op ignored; start held in the done cycle -> second op accepted, busy stays 1.
REQ-036 rst pulsed at edge 2 of an op on A=0x00, B=0x01 -> busy=0, all flags 0 at once; no done for 10 cycles.
REQ-037 EARLY_EXIT=0, A=0xC0, B=0x00 -> done after 4 edges, A_great_B=1; A changed to 0x00 during busy has no effect.
REQ-038 WIDTH=2, CHUNK=1, exhaustive 16 unsigned pairs -> flags match the truth table; done after 1 or 2 edges per REQ-023.
